// File: rtl/val2_shift_pipe.sv
// Purpose : ARM shifter-operand unit (Val2 + shifter carry-out) for the EXE stage.
// Latency : PIPE_STAGES cycles from capture to out_valid; one result per cycle when out_ready is held.
// Backpr. : in_ready = !out_valid | out_ready; when low every stage freezes and outputs hold.
//
// Ports: clk/rst (sync, active-high), flush (kills in-flight entries),
//        in_valid/in_ready + Val_Rm, Val_Rs, Shift_operand, I_bit, Reg_shift, carry_in, in_tag,
//        out_valid/out_ready + Val2, shift_carry, out_tag.
module val2_shift_pipe #(
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Val_Rm,
    input  logic [31:0]      Val_Rs,
    input  logic [11:0]      Shift_operand,
    input  logic             I_bit,
    input  logic             Reg_shift,
    input  logic             carry_in,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      Val2,
    output logic             shift_carry,
    output logic [TAG_W-1:0] out_tag
);

    // Every operand form is reduced to one of these kinds plus a 1..31 amount
    // where relevant; all the "n=0 / n>=32" corner cases become fixed kinds.
    typedef enum logic [2:0] {
        K_PASS, K_LSL, K_LSR, K_ASR, K_ROR, K_ZERO, K_SIGN, K_RRX
    } kind_t;

    typedef struct packed {
        logic [31:0]      src;
        kind_t            kind;
        logic [4:0]       amt;
        logic             c_fix;   // carry for PASS/ZERO kinds, carry_in for RRX
        logic [TAG_W-1:0] tag;
    } dec_t;

    dec_t       dec;
    dec_t       ex;
    logic       pre_v;
    logic       en;
    logic [1:0] sh_type;
    logic [7:0] rs_n;
    logic [31:0] res;
    logic        cout;
    logic [5:0]  lsh;
    logic [4:0]  cidx_hi;
    logic [4:0]  cidx_lo;
    logic        unused_rs;

    assign unused_rs = ^Val_Rs[31:8];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- decode ----------------
    always_comb begin
        dec       = '0;
        dec.src   = Val_Rm;
        dec.kind  = K_PASS;
        dec.amt   = '0;
        dec.c_fix = carry_in;
        dec.tag   = in_tag;
        sh_type   = Shift_operand[6:5];
        rs_n      = Val_Rs[7:0];
        if (I_bit) begin
            dec.src  = {24'd0, Shift_operand[7:0]};
            dec.amt  = {Shift_operand[11:8], 1'b0};
            dec.kind = (Shift_operand[11:8] == 4'd0) ? K_PASS : K_ROR;
        end else if (!Reg_shift) begin
            dec.amt = Shift_operand[11:7];
            if (Shift_operand[11:7] == 5'd0) begin
                unique case (sh_type)
                    2'd0: dec.kind = K_PASS;
                    2'd1: begin dec.kind = K_ZERO; dec.c_fix = Val_Rm[31]; end
                    2'd2: dec.kind = K_SIGN;
                    default: dec.kind = K_RRX;
                endcase
            end else begin
                unique case (sh_type)
                    2'd0: dec.kind = K_LSL;
                    2'd1: dec.kind = K_LSR;
                    2'd2: dec.kind = K_ASR;
                    default: dec.kind = K_ROR;
                endcase
            end
        end else if (rs_n != 8'd0) begin
            dec.amt = rs_n[4:0];
            unique case (sh_type)
                2'd0: begin
                    if (rs_n < 8'd32)       dec.kind = K_LSL;
                    else if (rs_n == 8'd32) begin dec.kind = K_ZERO; dec.c_fix = Val_Rm[0]; end
                    else                    begin dec.kind = K_ZERO; dec.c_fix = 1'b0; end
                end
                2'd1: begin
                    if (rs_n < 8'd32)       dec.kind = K_LSR;
                    else if (rs_n == 8'd32) begin dec.kind = K_ZERO; dec.c_fix = Val_Rm[31]; end
                    else                    begin dec.kind = K_ZERO; dec.c_fix = 1'b0; end
                end
                2'd2: dec.kind = (rs_n < 8'd32) ? K_ASR : K_SIGN;
                default: begin
                    // Multiples of 32 rotate back to Rm but still produce a carry.
                    if (rs_n[4:0] == 5'd0) begin dec.kind = K_PASS; dec.c_fix = Val_Rm[31]; end
                    else                   dec.kind = K_ROR;
                end
            endcase
        end
    end

    // ---------------- optional decode register ----------------
    generate
        if (PIPE_STAGES == 2) begin : g_two
            dec_t s1_dat;
            logic s1_v;
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_v   <= 1'b0;
                    s1_dat <= '0;
                end else if (flush) begin
                    s1_v   <= 1'b0;
                end else if (en) begin
                    s1_v <= in_valid;
                    if (in_valid) s1_dat <= dec;
                end
            end
            assign ex    = s1_dat;
            assign pre_v = s1_v;
        end else begin : g_one
            assign ex    = dec;
            assign pre_v = in_valid;
        end
    endgenerate

    // ---------------- shift ----------------
    always_comb begin
        res     = ex.src;
        cout    = ex.c_fix;
        lsh     = 6'd32 - {1'b0, ex.amt};
        cidx_hi = lsh[4:0];          // amt is 1..31 here, so 32-amt fits
        cidx_lo = ex.amt - 5'd1;
        unique case (ex.kind)
            K_LSL:  begin res = ex.src << ex.amt;                     cout = ex.src[cidx_hi]; end
            K_LSR:  begin res = ex.src >> ex.amt;                     cout = ex.src[cidx_lo]; end
            K_ASR:  begin res = $signed(ex.src) >>> ex.amt;           cout = ex.src[cidx_lo]; end
            K_ROR:  begin res = (ex.src >> ex.amt) | (ex.src << lsh); cout = ex.src[cidx_lo]; end
            K_ZERO: res = '0;
            K_SIGN: begin res = {32{ex.src[31]}};                     cout = ex.src[31]; end
            K_RRX:  begin res = {ex.c_fix, ex.src[31:1]};             cout = ex.src[0]; end
            default: ;
        endcase
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            Val2        <= '0;
            shift_carry <= 1'b0;
            out_tag     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (en) begin
            out_valid <= pre_v;
            if (pre_v) begin
                Val2        <= res;
                shift_carry <= cout;
                out_tag     <= ex.tag;
            end
        end
    end

endmodule

// File: tb/tb_val2_shift_pipe.sv
// Purpose : self-checking bench for val2_shift_pipe (2-stage build) against a behavioural model.
// Latency : expects results PIPE_STAGES cycles after capture, in order.
// Backpr. : drives random out_ready stalls and checks held outputs stay stable.
module tb_val2_shift_pipe;
    localparam int P  = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   Val_Rm, Val_Rs, Val2;
    logic [11:0]   Shift_operand;
    logic          I_bit, Reg_shift, carry_in, shift_carry;
    logic [TW-1:0] in_tag, out_tag;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    logic [TW-1:0] tag_ctr = '0;

    logic [TW+32:0] exp_q[$];
    logic           stall_prev = 1'b0;
    logic [31:0]    h_val;
    logic           h_c;
    logic [TW-1:0]  h_tag;

    always #5 clk = ~clk;

    val2_shift_pipe #(.PIPE_STAGES(P), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .Val_Rm(Val_Rm), .Val_Rs(Val_Rs), .Shift_operand(Shift_operand),
        .I_bit(I_bit), .Reg_shift(Reg_shift), .carry_in(carry_in), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .Val2(Val2), .shift_carry(shift_carry), .out_tag(out_tag)
    );

    // Reference: the architectural rules written as wide arithmetic shifts.
    function automatic logic [32:0] model(input logic [31:0] rm, input logic [7:0] rs,
                                          input logic [11:0] so, input logic ib,
                                          input logic rsh, input logic cin);
        logic [63:0] t;
        logic [31:0] v;
        logic        c;
        int          n, k;
        logic [1:0]  ty;
        ty = so[6:5];
        if (ib) begin
            n = 2 * int'(so[11:8]);
            t = {24'd0, so[7:0], 24'd0, so[7:0]} >> n;
            v = t[31:0];
            c = (n == 0) ? cin : v[31];
        end else begin
            n = rsh ? int'(rs) : int'(so[11:7]);
            if (n == 0 && (rsh || ty == 2'd0)) begin
                v = rm; c = cin;
            end else if (n == 0 && ty == 2'd3) begin
                v = {cin, rm[31:1]}; c = rm[0];
            end else begin
                if (n == 0) n = 32;
                case (ty)
                    2'd0: begin t = {32'd0, rm} << n; v = t[31:0];  c = t[32]; end
                    2'd1: begin t = {rm, 32'd0} >> n; v = t[63:32]; c = t[31]; end
                    2'd2: begin t = $signed({rm, 32'd0}) >>> n; v = t[63:32]; c = t[31]; end
                    default: begin
                        k = n % 32;
                        if (k == 0) begin v = rm; c = rm[31]; end
                        else begin t = {rm, rm} >> k; v = t[31:0]; c = v[31]; end
                    end
                endcase
            end
        end
        return {c, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample/score at negedge, then move to just after the posedge.
    task automatic cycle();
        logic [TW+32:0] e;
        @(negedge clk);
        if (rst || flush) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_vld", out_valid, 1);
                chk("stall_val", Val2, h_val);
                chk("stall_c", shift_carry, h_c);
                chk("stall_tag", out_tag, h_tag);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("res_val", Val2, e[31:0]);
                    chk("res_c", shift_carry, e[32]);
                    chk("res_tag", out_tag, e[TW+32:33]);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_tag, model(Val_Rm, Val_Rs[7:0], Shift_operand, I_bit, Reg_shift, carry_in)});
                n_acc++;
            end
            stall_prev = out_valid && !out_ready;
            h_val = Val2; h_c = shift_carry; h_tag = out_tag;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] so,
                          input logic ib, input logic rsh, input logic cin);
        Val_Rm = rm; Val_Rs = rs; Shift_operand = so;
        I_bit = ib; Reg_shift = rsh; carry_in = cin;
        in_tag = tag_ctr; tag_ctr = tag_ctr + 1'b1;
    endtask

    task automatic rand_in();
        set_in($urandom, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40)),
               12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Single operand through an empty pipe, checked against fixed values.
    task automatic directed(input string tag, input logic [31:0] rm, input logic [31:0] rs,
                            input logic [11:0] so, input logic ib, input logic rsh,
                            input logic cin, input logic [31:0] ev, input logic ec);
        set_in(rm, rs, so, ib, rsh, cin);
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int k = 1; k < P; k++) begin
            chk({tag, "_lat"}, out_valid, 0);
            cycle();
        end
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_val"}, Val2, ev);
        chk({tag, "_c"}, shift_carry, ec);
        cycle();
    endtask

    task automatic drain(input string tag);
        int b;
        in_valid = 1'b0; out_ready = 1'b1; b = 0;
        while ((exp_q.size() != 0 || out_valid) && b < 20) begin cycle(); b++; end
        chk({tag, "_left"}, exp_q.size(), 0);
        chk({tag, "_idle"}, out_valid, 0);
    endtask

    initial begin
        int sent, last_acc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_in('0, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle(); cycle();
        chk("rst_vld", out_valid, 0);
        chk("rst_val", Val2, 0);
        chk("rst_c", shift_carry, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_rdy", in_ready, 1);
        rst = 1'b0;

        // Operand corner cases
        directed("imm_rot",  32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF000000, 1'b1);
        directed("imm_rot0", 32'h0, 32'h0, 12'h0AB, 1'b1, 1'b0, 1'b1, 32'h000000AB, 1'b1);
        directed("lsr_n0",   32'h80000001, 32'h0, 12'h020, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        directed("rrx",      32'h80000001, 32'h0, 12'h060, 1'b0, 1'b0, 1'b1, 32'hC0000000, 1'b1);
        directed("lsl_r32",  32'h80000001, 32'd32, 12'h000, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        directed("lsl_r33",  32'h80000001, 32'd33, 12'h000, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
        directed("asr_r40",  32'h80000001, 32'd40, 12'h040, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1);
        directed("ror_r32",  32'h80000001, 32'd32, 12'h060, 1'b0, 1'b1, 1'b0, 32'h80000001, 1'b1);
        directed("reg_n0",   32'h12345678, 32'h100, 12'h020, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1);

        // 8 back-to-back inputs with out_ready cycling 1-0-1
        sent = 0; last_acc = n_acc;
        rand_in();
        for (int cyc = 0; sent < 8 && cyc < 100; cyc++) begin
            in_valid = 1'b1;
            out_ready = (cyc % 3 != 1);
            cycle();
            if (n_acc != last_acc) begin sent++; last_acc = n_acc; rand_in(); end
        end
        chk("b2b_sent", sent, 8);
        drain("b2b");

        // Flush with two entries in flight; a capture in the same cycle is dropped
        out_ready = 1'b0; in_valid = 1'b1;
        rand_in(); cycle();
        rand_in(); cycle();
        chk("fl_pre_vld", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1; rand_in();
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_vld", out_valid, 0);
        cycle();
        chk("fl_drop", out_valid, 0);
        directed("post_fl", 32'h0, 32'h0, 12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF000000, 1'b1);

        // Random traffic with random stalls
        last_acc = n_acc;
        rand_in();
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (n_acc != last_acc) begin last_acc = n_acc; rand_in(); end
        end
        drain("rand");

        // Reset in the middle of a stream
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin rand_in(); cycle(); end
        rst = 1'b1;
        cycle();
        chk("mrst_vld", out_valid, 0);
        chk("mrst_val", Val2, 0);
        chk("mrst_c", shift_carry, 0);
        chk("mrst_tag", out_tag, 0);
        chk("mrst_rdy", in_ready, 1);
        rst = 1'b0; in_valid = 1'b0;
        cycle();
        chk("mrst_s1", out_valid, 0);
        directed("post_rst", 32'h80000001, 32'h0, 12'h060, 1'b0, 1'b0, 1'b1, 32'hC0000000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
